obi_spi_master_arbiter: RTL

- Shares the single OBI master port of the SPI slave subsystem between two requesters: port 0 is the SPI slave bus plug, port 1 is a secondary master (debug/DMA).
- Arbitrates address phases round-robin and holds an arbitration decision while the winning request is ungranted, as OBI requires.
- Tracks in-order outstanding transactions so each r_valid/r_data beat is routed back to the port that issued it.

---
 rtl/obi_spi_master_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/obi_spi_master_arbiter.sv
// Two-port OBI arbiter in front of the SPI slave subsystem's master port, with in-order response routing.
// Define OBI_ARB_FIXED_PRIO_EN to make port 0 always win unlocked arbitration instead of round-robin.
module obi_spi_master_arbiter #(
    parameter int OBI_ADDR_WIDTH  = 32,
    parameter int OBI_DATA_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      obi_aclk,
    input  logic                      obi_areset,
    input  logic                      s0_req,
    output logic                      s0_gnt,
    input  logic [OBI_ADDR_WIDTH-1:0] s0_addr,
    input  logic                      s0_we,
    input  logic [OBI_DATA_WIDTH-1:0] s0_w_data,
    output logic                      s0_r_valid,
    output logic [OBI_DATA_WIDTH-1:0] s0_r_data,
    input  logic                      s1_req,
    output logic                      s1_gnt,
    input  logic [OBI_ADDR_WIDTH-1:0] s1_addr,
    input  logic                      s1_we,
    input  logic [OBI_DATA_WIDTH-1:0] s1_w_data,
    output logic                      s1_r_valid,
    output logic [OBI_DATA_WIDTH-1:0] s1_r_data,
    output logic                      obi_master_req,
    input  logic                      obi_master_gnt,
    output logic [OBI_ADDR_WIDTH-1:0] obi_master_addr,
    output logic                      obi_master_we,
    output logic [OBI_DATA_WIDTH-1:0] obi_master_w_data,
    input  logic                      obi_master_r_valid,
    input  logic [OBI_DATA_WIDTH-1:0] obi_master_r_data,
    output logic                      obi_master_r_ready,
    output logic                      err_unexp_rsp
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: an address phase transfers on a cycle where req and gnt are both high;
    // a response beat transfers on any cycle with r_valid high (r_ready is constant 1).
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t      lock_state, lock_state_next;
    logic             lock;
    logic             lock_id;
    logic             rr_last;
    logic             arb_sel;
    logic             sel;
    logic             sel_req;
    logic             sel_gnt;
    logic             full;
    logic             pop;
    logic             head_id;
    logic             id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    assign full = (count == CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        arb_sel = 1'b0;
`ifdef OBI_ARB_FIXED_PRIO_EN
        if (!s0_req && s1_req) arb_sel = 1'b1;
`else
        if (s0_req && s1_req)  arb_sel = ~rr_last;
        else if (s1_req)       arb_sel = 1'b1;
`endif
    end

    assign sel     = lock ? lock_id : arb_sel;
    assign sel_req = sel ? s1_req : s0_req;

    assign obi_master_req     = sel_req & ~full & ~obi_areset;
    assign obi_master_addr    = sel ? s1_addr   : s0_addr;
    assign obi_master_we      = sel ? s1_we     : s0_we;
    assign obi_master_w_data  = sel ? s1_w_data : s0_w_data;
    assign obi_master_r_ready = 1'b1;

    assign sel_gnt = obi_master_gnt & obi_master_req;
    assign s0_gnt  = sel_gnt & ~sel;
    assign s1_gnt  = sel_gnt & sel;

    // Lock FSM: state register
    always_ff @(posedge obi_aclk) begin
        if (obi_areset) begin
            lock_state <= UNLOCKED;
            lock_id    <= 1'b0;
        end else begin
            lock_state <= lock_state_next;
            if (lock_state == UNLOCKED && obi_master_req && !obi_master_gnt)
                lock_id <= sel;
        end
    end

    // Lock FSM: next state
    always_comb begin
        lock_state_next = lock_state;
        case (lock_state)
            UNLOCKED: if (obi_master_req && !obi_master_gnt) lock_state_next = LOCKED;
            LOCKED:   if (sel_gnt)                           lock_state_next = UNLOCKED;
            default:  lock_state_next = UNLOCKED;
        endcase
    end

    // Lock FSM: outputs
    always_comb begin
        lock = 1'b0;
        if (lock_state == LOCKED) lock = 1'b1;
    end

    // Tracker of issuing-port IDs, popped in order as responses return.
    assign head_id = id_mem[rd_ptr];
    assign pop     = obi_master_r_valid & (count != '0);

    assign s0_r_valid = pop & ~head_id & ~obi_areset;
    assign s1_r_valid = pop &  head_id & ~obi_areset;
    assign s0_r_data  = obi_master_r_data;
    assign s1_r_data  = obi_master_r_data;

    always_ff @(posedge obi_aclk) begin
        if (sel_gnt) id_mem[wr_ptr] <= sel;
    end

    always_ff @(posedge obi_aclk) begin
        if (obi_areset) begin
            rr_last       <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (sel_gnt) begin
                rr_last <= sel;
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (sel_gnt && !pop)      count <= count + CNT_W'(1);
            else if (!sel_gnt && pop) count <= count - CNT_W'(1);
            if (obi_master_r_valid && count == '0) err_unexp_rsp <= 1'b1;
        end
    end

endmodule
